// File: rtl/dmem_responder_pkg.sv
// Shared types for the wait-state data-memory responder: FSM states, lane geometry
// and the latched request record.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} dmem_state_t;

  localparam int LANES    = 4;
  localparam int OFFSET_W = 2;

  typedef struct packed {
    logic             we;
    logic [LANES-1:0] byte_enable;
    logic [29:0]      word_index;
    logic [31:0]      write_data;
    logic             range_err;
  } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// LSU <-> responder memory port; master is the LSU, slave is the responder.
interface dmem_responder_if;
  logic        req_enable;
  logic        req_we;
  logic [3:0]  req_byte_enable;
  logic [31:0] req_address;
  logic [31:0] req_write_data;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_read_data;
  logic        resp_error;
  logic        stall;

  modport master (
    output req_enable, req_we, req_byte_enable, req_address, req_write_data,
    input  req_ready, resp_valid, resp_read_data, resp_error, stall
  );

  modport slave (
    input  req_enable, req_we, req_byte_enable, req_address, req_write_data,
    output req_ready, resp_valid, resp_read_data, resp_error, stall
  );
endinterface

// File: rtl/dmem_array.sv
// Word array with per-byte-lane write enables and a registered read port.
// A read and a write on the same edge return the pre-write word.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic             clock,
  input  logic [LANES-1:0] wr_lanes,
  input  logic             rd_en,
  input  logic [AW-1:0]    addr,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_lanes[i]) mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
    if (rd_en) rd_data <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: one access per LATENCY+1 cycles, response LATENCY
// cycles after acceptance; stalls the pipeline while a request is outstanding.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input logic             clock,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int AW = ADDR_WIDTH - OFFSET_W;

  dmem_state_t      state, state_nxt;
  logic [3:0]       cnt;
  dmem_req_t        lat, inc, cur;
  logic             accept, enter_resp;
  logic [LANES-1:0] wr_lanes;
  logic [31:0]      rd_word;
  logic             unused_bits;

  assign inc = '{we:          bus.req_we,
                 byte_enable: bus.req_byte_enable,
                 word_index:  bus.req_address[31:OFFSET_W],
                 write_data:  bus.req_write_data,
                 range_err:   |bus.req_address[31:ADDR_WIDTH]};

  // With LATENCY = 1 the RESP-entry edge is the acceptance edge, so the live request is used.
  assign cur        = (state == IDLE) ? inc : lat;
  assign accept     = (state == IDLE) && bus.req_enable;
  assign enter_resp = ((state == BUSY) && (cnt == 4'd1)) || (accept && (LATENCY == 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.req_enable) state_nxt = (LATENCY == 1) ? RESP : BUSY;
      BUSY:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready      = (state == IDLE);
    bus.resp_valid     = (state == RESP);
    bus.resp_error     = (state == RESP) && lat.range_err;
    bus.resp_read_data = ((state == RESP) && !lat.we && !lat.range_err) ? rd_word : '0;
    bus.stall          = bus.req_enable && (state != RESP);
  end

  // The counter reaches 0 on the RESP-entry edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      lat <= '0;
    end else if (accept) begin
      cnt <= 4'(LATENCY - 1);
      lat <= inc;
    end else if (state == BUSY) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign wr_lanes = (enter_resp && cur.we && !cur.range_err) ? cur.byte_enable : '0;

  dmem_array #(.AW(AW)) u_array (
    .clock   (clock),
    .wr_lanes(wr_lanes),
    .rd_en   (enter_resp),
    .addr    (cur.word_index[AW-1:0]),
    .wr_data (cur.write_data),
    .rd_data (rd_word)
  );

  assign unused_bits = ^{bus.req_address[OFFSET_W-1:0], cur.word_index[29:AW]};

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 4, 1) share one stimulus port,
// selected by sel; expectations come from constant tables and an associative-array model.
module tb_dmem_responder;

  logic        clock = 0;
  logic        rst2, rst4, rst1;
  logic        en, we;
  logic [3:0]  be;
  logic [31:0] addr, wd;
  int          sel;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  dmem_responder_if if2 ();
  dmem_responder_if if4 ();
  dmem_responder_if if1 ();

  dmem_responder #(.ADDR_WIDTH(12), .LATENCY(2)) u2 (.clock(clock), .reset(rst2), .bus(if2));
  dmem_responder #(.ADDR_WIDTH(12), .LATENCY(4)) u4 (.clock(clock), .reset(rst4), .bus(if4));
  dmem_responder #(.ADDR_WIDTH(12), .LATENCY(1)) u1 (.clock(clock), .reset(rst1), .bus(if1));

  assign if2.req_enable = en && (sel == 0);
  assign if4.req_enable = en && (sel == 1);
  assign if1.req_enable = en && (sel == 2);
  assign if2.req_we = we;  assign if4.req_we = we;  assign if1.req_we = we;
  assign if2.req_byte_enable = be;  assign if4.req_byte_enable = be;  assign if1.req_byte_enable = be;
  assign if2.req_address = addr;  assign if4.req_address = addr;  assign if1.req_address = addr;
  assign if2.req_write_data = wd;  assign if4.req_write_data = wd;  assign if1.req_write_data = wd;

  logic        o_ready, o_valid, o_err, o_stall;
  logic [31:0] o_rd;
  assign o_ready = (sel == 0) ? if2.req_ready      : (sel == 1) ? if4.req_ready      : if1.req_ready;
  assign o_valid = (sel == 0) ? if2.resp_valid     : (sel == 1) ? if4.resp_valid     : if1.resp_valid;
  assign o_err   = (sel == 0) ? if2.resp_error     : (sel == 1) ? if4.resp_error     : if1.resp_error;
  assign o_stall = (sel == 0) ? if2.stall          : (sel == 1) ? if4.stall          : if1.stall;
  assign o_rd    = (sel == 0) ? if2.resp_read_data : (sel == 1) ? if4.resp_read_data : if1.resp_read_data;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic int lat_of(input int s);
    return (s == 0) ? 2 : (s == 1) ? 4 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference memory: key = instance*4096 + word index; a request is out of range when any
  // address bit at or above bit 12 is set.
  logic [31:0] mdl [int];

  task automatic model(input int s, input bit w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] erd, output bit eerr);
    int key;
    logic [31:0] old;
    eerr = (a[31:12] != 20'h0);
    erd  = 32'h0;
    if (!eerr) begin
      key = s * 4096 + int'(a[11:2]);
      old = mdl.exists(key) ? mdl[key] : 32'h0;
      if (w) begin
        for (int i = 0; i < 4; i++) if (b[i]) old[8*i +: 8] = d[8*i +: 8];
        mdl[key] = old;
      end else begin
        erd = old;
      end
    end
  endtask

  // One full access on the selected instance; leaves en low in the response cycle.
  task automatic access(input bit w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] erd, input bit eerr,
                        input string nm, output int resp_cyc);
    int k, st, lt;
    bit got;
    lt = lat_of(sel);
    @(negedge clock);
    en = 1; we = w; be = b; addr = a; wd = d;
    #1;
    chk({nm, ".ready"}, {31'b0, o_ready}, 32'd1);
    st = 0; got = 0; k = 0;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) begin @(posedge clock); #1; end
      k = n;
      if (o_valid) begin got = 1; break; end
      st += int'(o_stall);
    end
    resp_cyc = cyc;
    if (!got) begin
      chk({nm, ".timeout"}, 32'd0, 32'd1);
    end else begin
      chk({nm, ".latency"}, k, lt);
      chk({nm, ".stall_cycles"}, st, lt);
      chk({nm, ".stall_at_resp"}, {31'b0, o_stall}, 32'd0);
      chk({nm, ".rdata"}, o_rd, erd);
      chk({nm, ".err"}, {31'b0, o_err}, {31'b0, eerr});
    end
    @(negedge clock);
    en = 0;
  endtask

  typedef struct {
    bit          w;
    logic [3:0]  b;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] erd;
    bit          eerr;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [31:0] erd, d, a;
    bit eerr, w;
    logic [3:0] b;
    int rc, prev, k, vcount;

    tbl[0]  = '{1, 4'hF, 32'h000, 32'hDEADBEEF, 32'h0, 0};
    tbl[1]  = '{0, 4'hF, 32'h000, 32'h0,        32'hDEADBEEF, 0};
    tbl[2]  = '{1, 4'hF, 32'h100, 32'h00000000, 32'h0, 0};
    tbl[3]  = '{1, 4'h1, 32'h100, 32'h000000AA, 32'h0, 0};
    tbl[4]  = '{1, 4'h2, 32'h100, 32'h0000BB00, 32'h0, 0};
    tbl[5]  = '{1, 4'h4, 32'h100, 32'h00CC0000, 32'h0, 0};
    tbl[6]  = '{1, 4'h8, 32'h100, 32'hDD000000, 32'h0, 0};
    tbl[7]  = '{0, 4'h0, 32'h100, 32'h0,        32'hDDCCBBAA, 0};
    tbl[8]  = '{1, 4'hF, 32'h200, 32'hCAFEBABE, 32'h0, 0};
    tbl[9]  = '{1, 4'h0, 32'h200, 32'h12345678, 32'h0, 0};
    tbl[10] = '{0, 4'hF, 32'h200, 32'h0,        32'hCAFEBABE, 0};
    tbl[11] = '{1, 4'hF, 32'h004, 32'hA5A5A5A5, 32'h0, 0};
    tbl[12] = '{1, 4'hF, 32'h1004, 32'h11111111, 32'h0, 1};
    tbl[13] = '{0, 4'hF, 32'h004, 32'h0,        32'hA5A5A5A5, 0};
    tbl[14] = '{0, 4'hF, 32'h1004, 32'h0,       32'h0, 1};

    sel = 0; en = 0; we = 0; be = 0; addr = 0; wd = 0;
    rst2 = 1; rst4 = 1; rst1 = 1;
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk("reset.ready", {31'b0, o_ready}, 32'd1);
      chk("reset.valid", {31'b0, o_valid}, 32'd0);
      chk("reset.rdata", o_rd, 32'd0);
      chk("reset.err", {31'b0, o_err}, 32'd0);
      chk("reset.stall_lo", {31'b0, o_stall}, 32'd0);
      en = 1; #1;
      chk("reset.stall_hi", {31'b0, o_stall}, 32'd1);
      en = 0;
    end
    @(negedge clock);
    rst2 = 0; rst4 = 0; rst1 = 0;
    sel = 0;

    foreach (tbl[i])
      access(tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].d, tbl[i].erd, tbl[i].eerr, "table", rc);

    // Drop req_enable after acceptance, then reset in the response cycle.
    @(negedge clock);
    en = 1; we = 1; be = 4'hF; addr = 32'h500; wd = 32'h77777777;
    @(posedge clock); #1;
    @(negedge clock); en = 0; #1;
    chk("drop.stall", {31'b0, o_stall}, 32'd0);
    k = 1;
    while (!o_valid && k < 20) begin @(posedge clock); #1; k++; end
    chk("drop.latency", k, 32'd2);
    rst2 = 1; #1;
    chk("rst_resp.valid", {31'b0, o_valid}, 32'd0);
    @(negedge clock); rst2 = 0;
    access(0, 4'hF, 32'h500, 32'h0, 32'h77777777, 0, "rst_resp.kept", rc);

    // Reset during the second BUSY cycle of a LATENCY=4 write.
    sel = 1;
    access(1, 4'hF, 32'h300, 32'h0BADF00D, 32'h0, 0, "l4.prior", rc);
    @(negedge clock);
    en = 1; we = 1; be = 4'hF; addr = 32'h300; wd = 32'h55AA55AA;
    @(posedge clock); #1;
    chk("l4.busy_ready", {31'b0, o_ready}, 32'd0);
    @(posedge clock); #1;
    rst4 = 1; #1;
    chk("l4.rst_ready", {31'b0, o_ready}, 32'd1);
    chk("l4.rst_valid", {31'b0, o_valid}, 32'd0);
    chk("l4.rst_rdata", o_rd, 32'd0);
    chk("l4.rst_err", {31'b0, o_err}, 32'd0);
    chk("l4.rst_stall_hi", {31'b0, o_stall}, 32'd1);
    en = 0; #1;
    chk("l4.rst_stall_lo", {31'b0, o_stall}, 32'd0);
    @(negedge clock); @(negedge clock); rst4 = 0;
    vcount = 0;
    repeat (10) begin @(posedge clock); #1; vcount += int'(o_valid); end
    chk("l4.no_resp", vcount, 32'd0);
    access(0, 4'hF, 32'h300, 32'h0, 32'h0BADF00D, 0, "l4.unchanged", rc);

    // LATENCY=1 back-to-back SW/LW pairs over 0x400..0x424.
    sel = 2;
    prev = -1;
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      a = 32'h400 + 32'(4 * i);
      access(1, 4'hF, a, d, 32'h0, 0, "l1.sw", rc);
      if (prev >= 0) chk("l1.gap", rc - prev, 32'd2);
      prev = rc;
      access(0, 4'hF, a, 32'h0, d, 0, "l1.lw", rc);
      chk("l1.gap", rc - prev, 32'd2);
      prev = rc;
    end

    // Randomized traffic against the model on the LATENCY=2 and LATENCY=4 instances.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int i = 0; i < 16; i++) begin
        d = $urandom;
        a = 32'h600 + 32'(4 * i);
        model(s, 1, 4'hF, a, d, erd, eerr);
        access(1, 4'hF, a, d, erd, eerr, "rnd.init", rc);
      end
      for (int i = 0; i < ((s == 0) ? 40 : 15); i++) begin
        w = $urandom_range(0, 1);
        b = 4'($urandom);
        d = $urandom;
        a = 32'h600 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(12, 31));
        model(s, w, b, a, d, erd, eerr);
        access(w, b, a, d, erd, eerr, "rnd", rc);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the load-store unit's word-aligned data-memory interface (address, write data, byte enables, enable, write-enable, read data). It replaces the zero-wait data memory with a wait-state memory: it latches each request, holds the pipeline through a programmable access latency, commits byte-lane writes, and returns read data with a one-cycle response strobe. It sits between the LSU's memory port and the backing storage in the MEM stage, and drives the stall input of the hazard unit.

## Interface
Parameters:
- ADDR_WIDTH, 12, byte-address bits decoded; storage is 2**(ADDR_WIDTH-2) 32-bit words
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_enable  in  1  request present (LSU mem_enable)
- req_we  in  1  1 = write, 0 = read
- req_byte_enable  in  4  write byte lanes; bit i covers data[8i+7:8i]
- req_address  in  32  byte address; bits [1:0] ignored
- req_write_data  in  32  lane-positioned store data
- req_ready  out  1  request accepted this cycle
- resp_valid  out  1  one-cycle response strobe
- resp_read_data  out  32  full word read; valid only while resp_valid
- resp_error  out  1  address out of range; valid only while resp_valid
- stall  out  1  hold the pipeline this cycle

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: req_ready = 1. If req_enable, latch we, byte_enable, address[ADDR_WIDTH-1:2], write data, and range flag (address[31:ADDR_WIDTH] != 0); load the wait counter with LATENCY-1; go to BUSY (or straight to RESP when LATENCY = 1).
- BUSY: decrement the counter; go to RESP on the edge where the counter is 0.
- Write commit happens on the edge entering RESP: each enabled lane is written; lanes with enable = 0 keep their value; byte_enable = 0000 writes nothing.
- Read: the word is sampled on the same edge, so resp_read_data shows the array contents before any write of this transaction. Read data for a write is don't-care and is driven 0.
- Out of range: resp_error = 1 in RESP, the write is suppressed, and resp_read_data = 0.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. No acceptance in RESP.
- stall = req_enable & (state != RESP). It deasserts in the response cycle so the pipeline advances on that edge.
- req_enable falling after acceptance does not abort the transaction: it completes, and stall stays 0.
- Request inputs are ignored outside IDLE.

## Timing
- Reset values: state IDLE, counter 0, req_ready 1, resp_valid 0, resp_read_data 0, resp_error 0, stall follows req_enable combinationally. Storage contents are not reset.
- Request in cycle 0 with IDLE: accepted at the end of cycle 0, resp_valid in cycle LATENCY, IDLE again in cycle LATENCY+1.
- Throughput: one access per LATENCY+1 cycles. Back-to-back requests are accepted in the cycle after RESP.
- stall is high in cycles 0..LATENCY-1 and low in cycle LATENCY.
- Reset asserted during BUSY returns the block to IDLE immediately. A pending write is never committed; no resp_valid follows.
- Reset asserted in the RESP cycle clears resp_valid asynchronously. A write already committed on the RESP-entry edge remains.

## Structure
- Package dmem_pkg holds:
  - state enum dmem_state_t {IDLE, BUSY, RESP}
  - LSU-side constants for lane count (4) and word byte-offset width (2)
  - the request struct dmem_req_t (we, byte_enable, word index, write data, range-error flag)
- Sub-module dmem_array: synchronous word array with a per-byte-lane write-enable and a registered read port, parameterised on word-address width. The responder holds the FSM, counter, request latch and output logic.

## Test plan
- Reset, then SW 0xDEADBEEF @0x000 and LW @0x000 with LATENCY = 2:
  - resp_valid asserted exactly 2 cycles after each acceptance
  - read returns 0xDEADBEEF
  - stall high for 2 cycles per access
- Word 0x00000000 @0x100, then byte writes of 0xAA, 0xBB, 0xCC, 0xDD with byte_enable 0001, 0010, 0100, 1000 (data lane-positioned): LW @0x100 returns 0xDDCCBBAA.
- Write 0x12345678 @0x200 with byte_enable 0000, over a prior value of 0xCAFEBABE: LW returns 0xCAFEBABE.
- Address 0x00001004 with ADDR_WIDTH = 12, write 0x11111111:
  - resp_error = 1 and read data 0
  - word 0x004 is unchanged
- SW 0x55AA55AA @0x300 with LATENCY = 4, reset pulsed in the second BUSY cycle:
  - no resp_valid follows
  - a later LW @0x300 returns the prior contents
  - all outputs match their reset values during reset
- LATENCY = 1, ten back-to-back alternating SW/LW to 0x400..0x424:
  - each response arrives 1 cycle after acceptance
  - accesses complete every 2 cycles
  - all read data matches what was written
